// File: rtl/uwasic_onboarding_pkg.sv
// Shared constants for the onboarding design: register map, SPI frame length
// and PWM prescale.
package uwasic_onboarding_pkg;

  localparam int FRAME_LEN    = 16;
  localparam int PWM_PRESCALE = 13;
  localparam int NUM_REGS     = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  localparam logic [4:0] FRAME_LEN_C   = 5'(FRAME_LEN);
  localparam logic [3:0] PRESCALE_LAST = 4'(PWM_PRESCALE - 1);

endpackage

// File: rtl/uwasic_onboarding_top_spi.sv
// Write-only SPI mode-0 peripheral: input synchronizers, edge detect,
// 16-bit shifter with overflow detection, and the five-register file.
module uwasic_onboarding_top_spi
  import uwasic_onboarding_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty
);

  // Bits [1:0] are the synchronizer, bit [2] holds the previous synced value.
  logic [2:0]  sclk_q, sclk_d;
  logic [2:0]  ncs_q, ncs_d;
  logic [1:0]  copi_q, copi_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic sclk_rise, ncs_fall, ncs_rise, commit;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign commit    = ncs_rise && (bit_cnt_q == FRAME_LEN_C) && !ovf_q &&
                     shift_q[15] && (shift_q[14:8] <= ADDR_DUTY);

  always_comb begin
    sclk_d    = {sclk_q[1:0], sclk};
    ncs_d     = {ncs_q[1:0], ncs};
    copi_d    = {copi_q[0], copi};
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ovf_d     = ovf_q;
    regs_d    = regs_q;
    if (ncs_fall) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (sclk_rise && !ncs_q[1]) begin
      if (bit_cnt_q == FRAME_LEN_C) begin
        ovf_d = 1'b1;
      end else begin
        shift_d   = {shift_q[14:0], copi_q[1]};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
    if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
      end
    end
  end

  // nCS synchronizer resets high so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= '0;
      ncs_q     <= '1;
      copi_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
      regs_q    <= regs_d;
    end
  end

  assign en_out = {regs_q[ADDR_EN_OUT_HI[2:0]], regs_q[ADDR_EN_OUT_LO[2:0]]};
  assign en_pwm = {regs_q[ADDR_EN_PWM_HI[2:0]], regs_q[ADDR_EN_PWM_LO[2:0]]};
  assign duty   = regs_q[ADDR_DUTY[2:0]];

endmodule

// File: rtl/uwasic_onboarding_top.sv
// Tiny Tapeout user top: SPI register bank, free-running 8-bit PWM and a
// registered per-bit output mux driving 16 outputs.
module uwasic_onboarding_top
  import uwasic_onboarding_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [3:0]  presc_q, presc_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] out_q, out_d;
  logic        pwm;
  logic        unused_ok;

  uwasic_onboarding_top_spi u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (ui_in[0]),
    .copi   (ui_in[1]),
    .ncs    (ui_in[2]),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .duty   (duty)
  );

  // Counters free-run; a duty change only alters the next compare.
  always_comb begin
    presc_d = presc_q + 4'd1;
    step_d  = step_q;
    if (presc_q == PRESCALE_LAST) begin
      presc_d = '0;
      step_d  = step_q + 8'd1;
    end
    pwm   = (duty == 8'hFF) || (step_q < duty);
    out_d = en_out & (~en_pwm | {16{pwm}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      step_q  <= '0;
      out_q   <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      out_q   <= out_d;
    end
  end

  assign uo_out    = out_q[7:0];
  assign uio_out   = out_q[15:8];
  assign uio_oe    = 8'hFF;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_uwasic_onboarding_top.sv
// Directed bench for uwasic_onboarding_top: SPI frames drive the register bank,
// a monitor compares {uio_oe, uio_out, uo_out} against queued expectations.
module tb_uwasic_onboarding_top;

  logic       clk;
  logic       rst_n;
  logic       sclk, copi, ncs;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] exp_q[$];
  string       name_q[$];

  assign ui_in  = {5'b0, ncs, copi, sclk};
  assign uio_in = 8'h00;

  uwasic_onboarding_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Scoreboard monitor: pops one expectation per falling edge when pending.
  initial begin
    logic [23:0] e;
    logic [23:0] act;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {uio_oe, uio_out, uo_out};
        tests_run++;
        if (act !== e) begin
          tests_failed++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    tests_run++;
    if (act != exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic expect_out(input string name, input logic [23:0] v);
    @(posedge clk);
    exp_q.push_back(v);
    name_q.push_back(name);
    repeat (2) @(posedge clk);
  endtask

  // Driver: mode-0 frame, MSB first, 6 clk per SCLK phase.
  task automatic spi_send(input logic [31:0] data, input int nbits);
    ncs = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = data[i];
      repeat (6) @(posedge clk);
      sclk = 1'b1;
      repeat (6) @(posedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(posedge clk);
    ncs = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_send({16'h0000, 1'b1, addr, data}, 16);
  endtask

  // Rise-to-rise period and high time of uo_out[0], sampled on falling edges.
  task automatic measure_pwm(output int period, output int high);
    logic prev, lvl;
    int waited;
    period = 0;
    high   = 0;
    waited = 0;
    @(negedge clk);
    lvl = uo_out[0];
    do begin
      @(negedge clk);
      prev = lvl;
      lvl  = uo_out[0];
      waited++;
    end while (!(lvl && !prev) && waited < 5000);
    if (waited >= 5000) begin
      check("pwm_first_edge_timeout", 0, 1);
      return;
    end
    do begin
      high += int'(lvl);
      period++;
      @(negedge clk);
      prev = lvl;
      lvl  = uo_out[0];
    end while (!(lvl && !prev) && period < 5000);
  endtask

  task automatic count_high(input int cycles, output int high);
    high = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      high += int'(uo_out[0]);
    end
  endtask

  initial begin
    int period, high;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(posedge clk);
    expect_out("reset", 24'hFF_00_00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    expect_out("after_reset", 24'hFF_00_00);

    spi_write(7'h00, 8'hF0);
    expect_out("wr_en_out_lo", 24'hFF_00_F0);
    spi_write(7'h01, 8'hCC);
    expect_out("wr_en_out_hi", 24'hFF_CC_F0);

    spi_send(32'h0000_00FF, 16);
    expect_out("read_frame_ignored", 24'hFF_CC_F0);
    spi_write(7'h30, 8'hFF);
    expect_out("addr_0x30_ignored", 24'hFF_CC_F0);
    spi_write(7'h05, 8'hFF);
    expect_out("addr_0x05_ignored", 24'hFF_CC_F0);
    spi_send(32'h0000_4007, 15);
    expect_out("short_frame_ignored", 24'hFF_CC_F0);
    spi_send(32'h0001_001F, 17);
    expect_out("long_frame_ignored", 24'hFF_CC_F0);

    spi_write(7'h00, 8'h0F);
    expect_out("wr_en_out_lo_2", 24'hFF_CC_0F);
    spi_write(7'h01, 8'h00);
    spi_write(7'h00, 8'h01);
    expect_out("out0_static_high", 24'hFF_00_01);
    spi_write(7'h02, 8'h01);
    expect_out("pwm_mode_duty0", 24'hFF_00_00);
    spi_write(7'h04, 8'hFF);
    expect_out("pwm_mode_dutyff", 24'hFF_00_01);
    spi_write(7'h01, 8'h80);
    spi_write(7'h03, 8'h80);
    expect_out("pwm_hi_bit15", 24'hFF_80_01);

    spi_write(7'h04, 8'h00);
    expect_out("duty0_outputs", 24'hFF_00_00);
    count_high(3400, high);
    check("duty0_const_low", high, 0);

    spi_write(7'h04, 8'h80);
    measure_pwm(period, high);
    check("duty80_period", period, 3328);
    check("duty80_high", high, 1664);

    spi_write(7'h04, 8'hFF);
    count_high(3400, high);
    check("dutyff_const_high", high, 3400);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
